// File: rtl/note_glyph_renderer.sv
// note_glyph_renderer
//   Streams pixel writes to a VGA adapter. Two operations:
//     draw  - render a row of N_GLYPHS bitmap glyphs at (x, y), one pixel
//             per clock, glyph-major, then row, then column
//     erase - flood the whole screen with bg_colour in raster order
//
// Ports
//   clk            single clock, rising edge
//   clear          asynchronous active-low reset
//   start, erase   operation requests, only looked at while idle (erase wins)
//   transparent    1: only set bits are written; 0: unset bits written in bg
//   x, y           string origin (top-left pixel of glyph 0)
//   bitmaps        glyph g occupies slice g; MSB of a slice is the top-left pixel
//   fg_colour      colour of set bits
//   bg_colour      colour of unset bits and of the erase fill
//   x_out, y_out, colour, writeEn   registered pixel-write port
//   busy           operation in progress
//   done           one-cycle completion pulse
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request; inputs latched on acceptance
// S_DRAW   | emitting one glyph pixel per clock
// S_FILL   | emitting one screen pixel per clock in bg colour
// S_FINISH | one cycle with done high, then back to idle
module note_glyph_renderer #(
   parameter int GLYPH_W   = 12,
   parameter int GLYPH_H   = 12,
   parameter int N_GLYPHS  = 3,
   parameter int GLYPH_GAP = 0,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120
) (
   input  logic                                   clk,
   input  logic                                   clear,
   input  logic                                   start,
   input  logic                                   erase,
   input  logic                                   transparent,
   input  logic [7:0]                             x,
   input  logic [6:0]                             y,
   input  logic [N_GLYPHS*GLYPH_W*GLYPH_H-1:0]    bitmaps,
   input  logic [2:0]                             fg_colour,
   input  logic [2:0]                             bg_colour,
   output logic [7:0]                             x_out,
   output logic [6:0]                             y_out,
   output logic [2:0]                             colour,
   output logic                                   writeEn,
   output logic                                   busy,
   output logic                                   done
);

   localparam int GLYPH_PIX = GLYPH_W * GLYPH_H;
   localparam int BM_W      = N_GLYPHS * GLYPH_PIX;
   localparam int DRAW_PIX  = BM_W;
   localparam int FILL_PIX  = SCREEN_W * SCREEN_H;
   localparam int MAX_PIX   = (DRAW_PIX > FILL_PIX) ? DRAW_PIX : FILL_PIX;

   localparam int CW  = (GLYPH_W  > 1) ? $clog2(GLYPH_W)  : 1;
   localparam int RW  = (GLYPH_H  > 1) ? $clog2(GLYPH_H)  : 1;
   localparam int GW  = (N_GLYPHS > 1) ? $clog2(N_GLYPHS) : 1;
   localparam int FXW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
   localparam int FYW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
   localparam int LW  = (MAX_PIX  > 1) ? $clog2(MAX_PIX)  : 1;
   localparam int IW  = (BM_W     > 1) ? $clog2(BM_W)     : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAW   = 2'd1,
      S_FILL   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t            state_q, state_d;

   logic [7:0]        x_org_q, x_org_d;
   logic [6:0]        y_org_q, y_org_d;
   logic [BM_W-1:0]   bitmaps_q, bitmaps_d;
   logic [2:0]        fg_q, fg_d;
   logic [2:0]        bg_q, bg_d;
   logic              transp_q, transp_d;

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [GW-1:0]     glyph_q, glyph_d;
   logic [FXW-1:0]    fill_x_q, fill_x_d;
   logic [FYW-1:0]    fill_y_q, fill_y_d;
   // pixels still to emit after the current one; terminal count is zero
   logic [LW-1:0]     remain_q, remain_d;

   logic [7:0]        x_out_q, x_out_d;
   logic [6:0]        y_out_q, y_out_d;
   logic [2:0]        colour_q, colour_d;
   logic              wr_en_q, wr_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // draw-pixel geometry, kept wide so clipping sees the untruncated value
   logic [15:0]       px_full;
   logic [15:0]       py_full;
   logic              in_screen;
   logic [IW-1:0]     bit_idx;
   logic              pix_bit;

   always_comb begin
      px_full   = 16'(x_org_q) + 16'(glyph_q) * 16'(GLYPH_W + GLYPH_GAP) + 16'(col_q);
      py_full   = 16'(y_org_q) + 16'(row_q);
      in_screen = (px_full < 16'(SCREEN_W)) && (py_full < 16'(SCREEN_H));
      bit_idx   = IW'(glyph_q * GLYPH_PIX + (GLYPH_PIX - 1) - (row_q * GLYPH_W + col_q));
      pix_bit   = bitmaps_q[bit_idx];
   end

   always_comb begin
      state_d   = state_q;
      x_org_d   = x_org_q;
      y_org_d   = y_org_q;
      bitmaps_d = bitmaps_q;
      fg_d      = fg_q;
      bg_d      = bg_q;
      transp_d  = transp_q;
      col_d     = col_q;
      row_d     = row_q;
      glyph_d   = glyph_q;
      fill_x_d  = fill_x_q;
      fill_y_d  = fill_y_q;
      remain_d  = remain_q;
      x_out_d   = x_out_q;
      y_out_d   = y_out_q;
      colour_d  = colour_q;
      wr_en_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (erase || start) begin
               x_org_d   = x;
               y_org_d   = y;
               bitmaps_d = bitmaps;
               fg_d      = fg_colour;
               bg_d      = bg_colour;
               transp_d  = transparent;
               col_d     = '0;
               row_d     = '0;
               glyph_d   = '0;
               fill_x_d  = '0;
               fill_y_d  = '0;
               busy_d    = 1'b1;
               if (erase) begin
                  state_d  = S_FILL;
                  remain_d = LW'(FILL_PIX - 1);
               end else begin
                  state_d  = S_DRAW;
                  remain_d = LW'(DRAW_PIX - 1);
               end
            end
         end

         S_DRAW: begin
            x_out_d  = px_full[7:0];
            y_out_d  = py_full[6:0];
            colour_d = pix_bit ? fg_q : bg_q;
            wr_en_d  = (pix_bit || !transp_q) && in_screen;

            if (col_q == CW'(GLYPH_W - 1)) begin
               col_d = '0;
               if (row_q == RW'(GLYPH_H - 1)) begin
                  row_d   = '0;
                  glyph_d = (glyph_q == GW'(N_GLYPHS - 1)) ? '0 : glyph_q + 1'b1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end

            if (remain_q == '0) state_d = S_FINISH;
            else                remain_d = remain_q - 1'b1;
         end

         S_FILL: begin
            x_out_d  = 8'(fill_x_q);
            y_out_d  = 7'(fill_y_q);
            colour_d = bg_q;
            wr_en_d  = 1'b1;

            if (fill_x_q == FXW'(SCREEN_W - 1)) begin
               fill_x_d = '0;
               fill_y_d = (fill_y_q == FYW'(SCREEN_H - 1)) ? '0 : fill_y_q + 1'b1;
            end else begin
               fill_x_d = fill_x_q + 1'b1;
            end

            if (remain_q == '0) state_d = S_FINISH;
            else                remain_d = remain_q - 1'b1;
         end

         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q   <= S_IDLE;
         x_org_q   <= '0;
         y_org_q   <= '0;
         bitmaps_q <= '0;
         fg_q      <= '0;
         bg_q      <= '0;
         transp_q  <= 1'b0;
         col_q     <= '0;
         row_q     <= '0;
         glyph_q   <= '0;
         fill_x_q  <= '0;
         fill_y_q  <= '0;
         remain_q  <= '0;
         x_out_q   <= '0;
         y_out_q   <= '0;
         colour_q  <= '0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_org_q   <= x_org_d;
         y_org_q   <= y_org_d;
         bitmaps_q <= bitmaps_d;
         fg_q      <= fg_d;
         bg_q      <= bg_d;
         transp_q  <= transp_d;
         col_q     <= col_d;
         row_q     <= row_d;
         glyph_q   <= glyph_d;
         fill_x_q  <= fill_x_d;
         fill_y_q  <= fill_y_d;
         remain_q  <= remain_d;
         x_out_q   <= x_out_d;
         y_out_q   <= y_out_d;
         colour_q  <= colour_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign x_out   = x_out_q;
   assign y_out   = y_out_q;
   assign colour  = colour_q;
   assign writeEn = wr_en_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: doc/note_glyph_renderer.md
NOTE_GLYPH_RENDERER -- requirements
Module: note_glyph_renderer

Interface
REQ-001 Parameter GLYPH_W, default 12, glyph width in pixels.
REQ-002 Parameter GLYPH_H, default 12, glyph height in pixels.
REQ-003 Parameter N_GLYPHS, default 3, glyphs per string (sharp, letter, octave).
REQ-004 Parameter GLYPH_GAP, default 0, blank pixels between adjacent glyphs.
REQ-005 Parameter SCREEN_W, default 160, and SCREEN_H, default 120, screen extent in pixels.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 clear  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  request to draw the glyph string; sampled in IDLE only.
REQ-009 erase  in  1  request to fill the whole screen with bg_colour; sampled in IDLE only.
REQ-010 transparent  in  1  1: plot set bits only; 0: also plot unset bits in bg_colour.
REQ-011 x  in  8 / y  in  7  string origin (top-left pixel of glyph 0).
REQ-012 bitmaps  in  N_GLYPHS*GLYPH_W*GLYPH_H  glyph g in slice g; pixel (col c, row r) at bit g*W*H + (W*H-1) - (r*W + c), MSB = top-left.
REQ-013 fg_colour  in  3 / bg_colour  in  3  set-bit and unset-bit/erase colours.
REQ-014 x_out  out  8 / y_out  out  7 / colour  out  3 / writeEn  out  1  registered pixel-write port to the VGA adapter.
REQ-015 busy  out  1  high from the edge accepting a request until the edge that asserts done.
REQ-016 done  out  1  single-cycle pulse on operation completion.

Function
REQ-017 States SHALL be IDLE, DRAW, FILL, FINISH; reset enters IDLE.
REQ-018 IDLE: erase=1 -> FILL; else start=1 -> DRAW; erase SHALL win when both are high.
REQ-019 On acceptance, x, y, bitmaps, fg_colour, bg_colour, transparent SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-020 start/erase while busy SHALL be ignored (not queued).
REQ-021 DRAW SHALL emit one pixel per clock: glyph 0..N_GLYPHS-1, within each glyph row 0..H-1, within each row col 0..W-1.
REQ-022 Pixel coordinates: x_out = x + g*(GLYPH_W+GLYPH_GAP) + c, y_out = y + r, computed at 9/8 bits before truncation.
REQ-023 Set bit: writeEn=1, colour=fg_colour; unset bit: writeEn=!transparent, colour=bg_colour.
REQ-024 Clipping: if untruncated x >= SCREEN_W or y >= SCREEN_H, writeEn SHALL be 0 for that pixel; no wrap-around; pixel slot still consumed.
REQ-025 Gap columns SHALL NOT be emitted; DRAW lasts exactly N_GLYPHS*GLYPH_W*GLYPH_H cycles.
REQ-026 FILL SHALL emit every screen pixel, x fastest, (0,0) to (SCREEN_W-1,SCREEN_H-1), writeEn=1, colour=bg_colour; lasts SCREEN_W*SCREEN_H cycles.
REQ-027 Latency: request sampled at edge k -> busy=1 after edge k; first pixel valid after edge k+1; last pixel valid after edge k+P (P = pixel count).
REQ-028 FINISH: after edge k+P+1, writeEn=0, done=1, busy=0 for exactly one cycle, then IDLE; a request may be accepted at edge k+P+2.
REQ-029 Outside DRAW/FILL, writeEn SHALL be 0; x_out/y_out SHALL hold their last values.
REQ-030 Counters SHALL be sized by $clog2 of their parameter bound; no counter shall exceed its bound.

Reset
REQ-031 clear=0 SHALL immediately force IDLE, writeEn=0, busy=0, done=0, x_out=0, y_out=0, colour=0, all counters 0.
REQ-032 clear asserted mid-DRAW/FILL SHALL abort with no further writes and no done pulse.
REQ-033 After clear returns high, the first request SHALL behave as from a fresh reset.

Verification
REQ-034 Defaults, x=10, y=20, glyph 0 all-ones, others zero, transparent=1, start pulse -> 144 writes at (10..21, 20..31) colour fg; 432 pixel cycles; done at cycle 433 after acceptance.
REQ-035 Same with transparent=0, bg_colour=3'b001 -> 432 writes, 288 of them colour 001; glyph 1 begins at x_out=22.
REQ-036 x=150, y=115, all-ones bitmaps -> writeEn=0 wherever x_out>=160 or y>=120 (pre-truncation), no coordinates wrapped to 0.
REQ-037 erase and start high together, bg_colour=3'b000 -> 19200 writes colour 000 in raster order, one done pulse, start not serviced.
REQ-038 start re-pulsed mid-DRAW, then clear=0 at pixel 50 -> re-pulse ignored; outputs zero asynchronously; no done; next start draws full string.
